// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling, byte strobe and framing-error strobe.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote (requires CLKS_PER_BIT >= 8).
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 25_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] END_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             w_rx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             sample_bit;
    logic             mid_hit;
    logic             end_hit;
    logic             cnt_clr;
    logic             shift_en;
    logic             valid_set;
    logic             ferr_set;

    assign mid_hit = (cnt == MID_CNT);
    assign end_hit = (cnt == END_CNT);
    assign o_busy  = (state != S_IDLE);

`ifdef UART_RX_MAJORITY_EN
    // Last two synchronized samples; with the current one they form the vote window.
    logic [1:0] hist;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], w_rx};
        end
    end

    assign sample_bit = (hist[1] & hist[0]) | (hist[1] & w_rx) | (hist[0] & w_rx);
`else
    assign sample_bit = w_rx;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!w_rx) state_next = S_START;
            S_START: if (mid_hit) state_next = sample_bit ? S_IDLE : S_DATA;
            S_DATA:  if (end_hit && (bit_idx == 3'd7)) state_next = S_STOP;
            S_STOP:  if (end_hit) state_next = sample_bit ? S_IDLE : S_BREAK;
            S_BREAK: if (w_rx) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath controls; the counter restarts on every state change and on each data bit
    always_comb begin
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        valid_set = 1'b0;
        ferr_set  = 1'b0;
        if ((state_next != state) || (state == S_IDLE) || (state == S_BREAK)) begin
            cnt_clr = 1'b1;
        end
        if ((state == S_DATA) && end_hit) begin
            cnt_clr  = 1'b1;
            shift_en = 1'b1;
        end
        if ((state == S_STOP) && end_hit) begin
            valid_set = sample_bit;
            ferr_set  = !sample_bit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta     <= 1'b1;
            w_rx        <= 1'b1;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta     <= i_rx;
            w_rx        <= rx_meta;
            cnt         <= cnt_clr ? '0 : cnt + CNT_W'(1);
            o_valid     <= valid_set;
            o_frame_err <= ferr_set;
            if (state == S_START) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift <= {sample_bit, shift[7:1]};
            end
            if (valid_set) begin
                o_data <= shift;
            end
        end
    end

endmodule
